bcd_digit_source: RTL and testbench

Sequential binary-to-BCD converter that produces the four 4-bit digits driving the seven-segment display scanner. It accepts a binary value through a valid/ready handshake and converts it with an iterative shift-add-3 (double-dabble) datapath, one bit per clock. It presents the result as four registered digit nibbles, which are updated atomically and held stable between conversions, and flags out-of-range inputs. It sits directly upstream of the display block; `digit3..digit0` connect one-to-one.

---
 rtl/bcd_digit_source.sv | 142 ++++++++++++++
 tb/tb_bcd_digit_source.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_source.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the display scanner.
// Optional build macro: BCD_OVERFLOW_HEX_EN shows raw hex of an out-of-range input instead of "EEEE".
module bcd_digit_source #(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    output logic [3:0]       digit3,
    output logic [3:0]       digit2,
    output logic [3:0]       digit1,
    output logic [3:0]       digit0,
    output logic             done,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [15:0]      digits_q, digits_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
`ifdef BCD_OVERFLOW_HEX_EN
    logic [15:0]      raw_q, raw_d;
`endif

    logic [15:0]      bcd_adj;
    logic [15:0]      ovf_digits;
    logic             in_over;

    // Per-nibble add-3 correction applied ahead of each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign in_over = (32'(in_value) > 32'd9999);

`ifdef BCD_OVERFLOW_HEX_EN
    assign ovf_digits = raw_q;
`else
    assign ovf_digits = 16'hEEEE;
`endif

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
`ifdef BCD_OVERFLOW_HEX_EN
        raw_d      = raw_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d       = in_value;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = in_over;
`ifdef BCD_OVERFLOW_HEX_EN
                    raw_d      = 16'(in_value);
`endif
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[14:0], sr_q[WIDTH-1]};
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                digits_d   = ovf_pend_q ? ovf_digits : bcd_q;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef BCD_OVERFLOW_HEX_EN
            raw_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
`ifdef BCD_OVERFLOW_HEX_EN
            raw_q      <= raw_d;
`endif
        end
    end

    assign in_ready = (state_q == IDLE);
    assign digit3   = digits_q[15:12];
    assign digit2   = digits_q[11:8];
    assign digit1   = digits_q[7:4];
    assign digit0   = digits_q[3:0];
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_digit_source.sv
// Self-checking bench for bcd_digit_source: directed corner cases plus random values
// checked against a decimal-arithmetic reference model.
module tb_bcd_digit_source;

    localparam int unsigned W = 14;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_value;
    logic [3:0]   digit3, digit2, digit1, digit0;
    logic         done;
    logic         overflow;

    int unsigned  total;
    int unsigned  bad;
    int unsigned  cyc;
    int unsigned  done_cyc;
    logic [15:0]  prev_dig;
    logic         prev_ovf;

    bcd_digit_source #(.WIDTH(W)) dut (
        .clk_100MHz (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .digit3     (digit3),
        .digit2     (digit2),
        .digit1     (digit1),
        .digit0     (digit0),
        .done       (done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] digits_now();
        return {digit3, digit2, digit1, digit0};
    endfunction

    // Reference: decimal digits by division, or the overflow display.
    function automatic logic [15:0] model_digits(input int unsigned v);
        logic [15:0] r;
        if (v > 9999) begin
`ifdef BCD_OVERFLOW_HEX_EN
            r = v[15:0];
`else
            r = 16'hEEEE;
`endif
        end else begin
            r[15:12] = 4'((v / 1000) % 10);
            r[11:8]  = 4'((v / 100) % 10);
            r[7:4]   = 4'((v / 10) % 10);
            r[3:0]   = 4'(v % 10);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Offers v, waits for the capture, checks hold behaviour and
    // the result cycle. With chain set, in_valid stays high carrying nextv afterwards.
    task automatic convert(input int unsigned v, input bit chain, input int unsigned nextv);
        int unsigned n;
        int unsigned hold_err;
        logic [15:0] exp_d;
        in_valid = 1'b1;
        in_value = W'(v);
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(n), 32'd0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        hold_err = 0;
        for (int k = 1; k <= int'(W) + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (chain) in_value = W'(nextv);
                else       in_valid = 1'b0;
            end
            if (done !== 1'b0 || in_ready !== 1'b0 || digits_now() !== prev_dig || overflow !== prev_ovf)
                hold_err++;
        end
        check($sformatf("hold_%0d", v), 32'(hold_err), 32'd0);
        @(negedge clk);
        exp_d = model_digits(v);
        check($sformatf("done_%0d", v), 32'(done), 32'd1);
        check($sformatf("ready_%0d", v), 32'(in_ready), 32'd1);
        check($sformatf("digits_%0d", v), 32'(digits_now()), 32'(exp_d));
        check($sformatf("ovf_%0d", v), 32'(overflow), 32'(v > 9999));
        prev_dig = exp_d;
        prev_ovf = (v > 9999);
        done_cyc = cyc;
    endtask

    initial begin
        int unsigned first_done;
        int unsigned v;
        int unsigned gap;
        int unsigned seen_done;
        total    = 0;
        bad      = 0;
        cyc      = 0;
        done_cyc = 0;
        prev_dig = '0;
        prev_ovf = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_digits", 32'(digits_now()), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(1234, 1'b0, 0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        convert(0, 1'b0, 0);
        convert(9999, 1'b0, 0);
        convert(10000, 1'b0, 0);
        convert(16383, 1'b0, 0);
        convert(5, 1'b0, 0);

        // Back-to-back with in_valid held high throughout.
        convert(42, 1'b1, 7);
        first_done = done_cyc;
        convert(7, 1'b0, 0);
        check("b2b_spacing", 32'(done_cyc - first_done), 32'(W + 2));

        // Abort a conversion of 5678 at T5 with an asynchronous reset.
        convert(9999, 1'b0, 0);
        in_valid = 1'b1;
        in_value = W'(5678);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_digits", 32'(digits_now()), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("midrst_no_done", 32'(seen_done), 32'd0);
        check("midrst_hold0", 32'(digits_now()), 32'd0);
        prev_dig = '0;
        prev_ovf = 1'b0;
        convert(321, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0:       v = $urandom_range(9990, 10010);
                1:       v = $urandom_range(0, 20);
                default: v = $urandom_range(0, (1 << W) - 1);
            endcase
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            convert(v, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
